segre_main_memory: RTL and testbench



---
 rtl/segre_main_memory.sv | 188 ++++++++++++++++++
 tb/tb_segre_main_memory.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/segre_main_memory.sv
// Memory-side responder for the Segre MMU: fixed-latency line reads and sub-word writes.
// Optional alignment/conflict checking is enabled by defining SEGRE_MEM_ALIGN_CHECK_EN.
module segre_main_memory #(
  parameter int MEM_BYTES = 65536,
  parameter int LATENCY   = 4,
  parameter int LANE_SIZE = 128,
  parameter int ADDR_SIZE = 32,
  parameter int WORD_SIZE = 32
) (
  input  logic                 clk_i,
  input  logic                 rsn_i,
  input  logic                 mem_rd_i,
  input  logic                 mem_wr_i,
  input  logic [ADDR_SIZE-1:0] mem_addr_i,
  input  logic [WORD_SIZE-1:0] mem_wr_data_i,
  input  logic [1:0]           mem_data_type_i,
  output logic [LANE_SIZE-1:0] mem_data_o,
  output logic                 mem_ready_o,
  output logic                 mem_busy_o,
  output logic                 mem_err_o
);

  localparam int IW         = $clog2(MEM_BYTES);
  localparam int LANE_BYTES = LANE_SIZE / 8;
  localparam int LW         = $clog2(LANE_BYTES);
  localparam int CW         = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [1:0] TYPE_BYTE = 2'd0;
  localparam logic [1:0] TYPE_HALF = 2'd1;
  localparam logic [1:0] TYPE_WORD = 2'd2;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [IW-1:0]          addr_q, addr_d;
  logic [WORD_SIZE-1:0]   wdata_q, wdata_d;
  logic [1:0]             type_q, type_d;
  logic                   rd_q, rd_d;
  logic                   wr_q, wr_d;
  logic                   err_q, err_d;
  logic                   ready_q, busy_q, resp_err_q;
  logic [LANE_SIZE-1:0]   data_q;
  logic [7:0]             mem_q [MEM_BYTES];
  logic [LANE_SIZE-1:0]   line_s;
  logic [IW-1:0]          line_addr_s;
  logic                   load_line_s;
  logic                   req_err_s;
  logic                   unused_addr_s;

  assign unused_addr_s = ^mem_addr_i;

`ifdef SEGRE_MEM_ALIGN_CHECK_EN
  logic misalign_s;
  assign misalign_s = ((mem_data_type_i == TYPE_HALF) && mem_addr_i[0]) ||
                      ((mem_data_type_i == TYPE_WORD) && (mem_addr_i[1:0] != 2'b00));
  assign req_err_s  = mem_wr_i && (mem_rd_i || misalign_s);
`else
  assign req_err_s  = 1'b0;
`endif

  // Gather the addressed line from the array, byte k at bits [8k+7:8k].
  always_comb begin
    line_s = '0;
    for (int k = 0; k < LANE_BYTES; k++) begin
      line_s[8*k +: 8] = mem_q[{line_addr_s[IW-1:LW], LW'(k)}];
    end
  end

  // Next-state, request capture and line-load decision.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    type_d      = type_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    err_d       = err_q;
    load_line_s = 1'b0;
    line_addr_s = addr_q;
    case (state_q)
      IDLE: begin
        line_addr_s = mem_addr_i[IW-1:0];
        if (mem_rd_i || mem_wr_i) begin
          addr_d  = mem_addr_i[IW-1:0];
          wdata_d = mem_wr_data_i;
          type_d  = mem_data_type_i;
          rd_d    = mem_rd_i;
          // a write colliding with a read, or flagged as erroneous, never reaches the array
          wr_d    = mem_wr_i && !mem_rd_i && !req_err_s;
          err_d   = req_err_s;
          if (LATENCY == 1) begin
            state_d     = RESP;
            cnt_d       = '0;
            load_line_s = mem_rd_i;
          end else begin
            state_d = BUSY;
            cnt_d   = CNT_INIT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (cnt_q <= CNT_ONE) begin
          state_d     = RESP;
          cnt_d       = '0;
          load_line_s = rd_q;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      RESP: begin
        state_d = IDLE;
        wr_d    = 1'b0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Control state and registered response outputs.
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      type_q     <= TYPE_BYTE;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      err_q      <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      resp_err_q <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      type_q     <= type_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      err_q      <= err_d;
      ready_q    <= (state_d == RESP);
      busy_q     <= (state_d != IDLE);
      resp_err_q <= (state_d == RESP) && err_d;
      if (load_line_s) begin
        data_q <= line_s;
      end
    end
  end

  // Array update on the edge leaving RESP; not reset so contents survive rsn_i.
  always_ff @(posedge clk_i) begin
    if ((state_q == RESP) && wr_q) begin
      case (type_q)
        TYPE_BYTE: begin
          mem_q[addr_q] <= wdata_q[7:0];
        end
        TYPE_HALF: begin
          mem_q[addr_q]          <= wdata_q[7:0];
          mem_q[addr_q + IW'(1)] <= wdata_q[15:8];
        end
        TYPE_WORD: begin
          mem_q[addr_q]          <= wdata_q[7:0];
          mem_q[addr_q + IW'(1)] <= wdata_q[15:8];
          mem_q[addr_q + IW'(2)] <= wdata_q[23:16];
          mem_q[addr_q + IW'(3)] <= wdata_q[31:24];
        end
        default: begin
          mem_q[addr_q] <= wdata_q[7:0];
        end
      endcase
    end
  end

  assign mem_data_o  = data_q;
  assign mem_ready_o = ready_q;
  assign mem_busy_o  = busy_q;
  assign mem_err_o   = resp_err_q;

endmodule

// File: tb/tb_segre_main_memory.sv
// Randomized bench for segre_main_memory against a byte-array reference model.
module tb_segre_main_memory;
  localparam int MEM_BYTES = 65536;
  localparam int LAT       = 4;

  logic         clk_i = 1'b0;
  logic         rsn_i = 1'b0;
  logic         mem_rd_i = 1'b0;
  logic         mem_wr_i = 1'b0;
  logic [31:0]  mem_addr_i = '0;
  logic [31:0]  mem_wr_data_i = '0;
  logic [1:0]   mem_data_type_i = '0;
  logic [127:0] mem_data_o;
  logic         mem_ready_o, mem_busy_o, mem_err_o;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0]   ref_mem   [MEM_BYTES];
  bit           ref_known [MEM_BYTES];
  logic [127:0] last_exp  = '0;
  logic [127:0] last_mask = '1;

`ifdef SEGRE_MEM_ALIGN_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  segre_main_memory #(.MEM_BYTES(MEM_BYTES), .LATENCY(LAT), .LANE_SIZE(128)) dut (
    .clk_i(clk_i), .rsn_i(rsn_i), .mem_rd_i(mem_rd_i), .mem_wr_i(mem_wr_i),
    .mem_addr_i(mem_addr_i), .mem_wr_data_i(mem_wr_data_i), .mem_data_type_i(mem_data_type_i),
    .mem_data_o(mem_data_o), .mem_ready_o(mem_ready_o), .mem_busy_o(mem_busy_o), .mem_err_o(mem_err_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int unsigned size_of(input logic [1:0] t);
    return (t == 2'd2) ? 4 : (t == 2'd1) ? 2 : 1;
  endfunction

  function automatic bit misaligned(input logic [31:0] a, input logic [1:0] t);
    return ((t == 2'd1) && a[0]) || ((t == 2'd2) && (a[1:0] != 2'b00));
  endfunction

  function automatic void ref_write(input logic [31:0] a, input logic [31:0] d, input logic [1:0] t);
    for (int k = 0; k < int'(size_of(t)); k++) begin
      int unsigned idx;
      idx = (a + 32'(k)) % MEM_BYTES;
      ref_mem[idx]   = d[8*k +: 8];
      ref_known[idx] = 1'b1;
    end
  endfunction

  function automatic void ref_line(input logic [31:0] a, output logic [127:0] l, output logic [127:0] m);
    int unsigned base;
    base = a & 32'(MEM_BYTES - 1) & 32'hFFFF_FFF0;
    l = '0;
    m = '0;
    for (int k = 0; k < 16; k++) begin
      if (ref_known[base + 32'(k)]) begin
        l[8*k +: 8] = ref_mem[base + 32'(k)];
        m[8*k +: 8] = 8'hFF;
      end
    end
  endfunction

  // One complete request/response; glitch pulses an extra write while the request is in flight.
  task automatic do_req(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] t, input bit glitch);
    bit exp_err, do_wr, seen;
    logic [127:0] el, em;
    exp_err = CHK && wr && (rd || misaligned(a, t));
    do_wr   = wr && !rd && !exp_err;
    mem_rd_i = rd; mem_wr_i = wr; mem_addr_i = a; mem_wr_data_i = d; mem_data_type_i = t;
    seen = 1'b0;
    for (int k = 1; k <= LAT + 4 && !seen; k++) begin
      @(posedge clk_i); #1;
      if (glitch && k == 2) begin
        mem_wr_i = 1'b1; mem_wr_data_i = ~d;
      end else if (glitch && k == 3) begin
        mem_wr_i = wr; mem_wr_data_i = d;
      end else begin
        mem_wr_i = mem_wr_i;
      end
      check_eq("busy_in_flight", 128'(mem_busy_o), 128'(1));
      if (mem_ready_o) begin
        seen = 1'b1;
        check_eq("latency", 128'(k), 128'(LAT));
      end
    end
    if (!seen) check_eq("ready_timeout", 128'(0), 128'(1));
    mem_rd_i = 1'b0; mem_wr_i = 1'b0;
    check_eq("err", 128'(mem_err_o), 128'(exp_err));
    if (rd) begin
      ref_line(a, el, em);
      check_eq("rdata", mem_data_o & em, el & em);
      last_exp = el; last_mask = em;
    end else begin
      check_eq("rdata_hold", mem_data_o & last_mask, last_exp & last_mask);
    end
    if (do_wr) ref_write(a, d, t);
    @(posedge clk_i); #1;
    check_eq("ready_pulse", 128'(mem_ready_o), 128'(0));
    check_eq("idle_busy", 128'(mem_busy_o), 128'(0));
  endtask

  initial begin
    // reset with random inputs
    for (int i = 0; i < 5; i++) begin
      mem_rd_i = 1'($urandom); mem_wr_i = 1'($urandom); mem_addr_i = $urandom;
      mem_wr_data_i = $urandom; mem_data_type_i = 2'($urandom_range(0, 2));
      @(posedge clk_i); #1;
      check_eq("rst_ready", 128'(mem_ready_o), 128'(0));
      check_eq("rst_busy", 128'(mem_busy_o), 128'(0));
      check_eq("rst_err", 128'(mem_err_o), 128'(0));
      check_eq("rst_data", mem_data_o, 128'(0));
    end
    mem_rd_i = 1'b0; mem_wr_i = 1'b0;
    rsn_i = 1'b1;
    @(posedge clk_i); #1;
    check_eq("post_rst_busy", 128'(mem_busy_o), 128'(0));

    // directed write/read and sub-word merges
    do_req(1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 2'd2, 1'b0);
    do_req(1'b1, 1'b0, 32'h108, 32'h0, 2'd0, 1'b0);
    check_eq("word_rd", 128'(mem_data_o[31:0]), 128'(32'hDEADBEEF));
    do_req(1'b0, 1'b1, 32'h103, 32'h000000AA, 2'd0, 1'b0);
    do_req(1'b0, 1'b1, 32'h106, 32'h00001234, 2'd1, 1'b0);
    do_req(1'b1, 1'b0, 32'h100, 32'h0, 2'd0, 1'b0);
    check_eq("sub_lo", 128'(mem_data_o[31:0]), 128'(32'hAAADBEEF));
    check_eq("sub_half", 128'(mem_data_o[63:48]), 128'(16'h1234));

    // wrap-around addressing and a request pulsed while busy
    do_req(1'b1, 1'b0, 32'(MEM_BYTES) + 32'h100, 32'h0, 2'd0, 1'b1);
    check_eq("wrap_rd", 128'(mem_data_o[31:0]), 128'(32'hAAADBEEF));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i); #1;
      check_eq("no_extra_ready", 128'(mem_ready_o), 128'(0));
    end
    do_req(1'b1, 1'b0, 32'h100, 32'h0, 2'd0, 1'b0);

    // reset while a write is in flight
    do_req(1'b0, 1'b1, 32'h200, 32'hCAFEF00D, 2'd2, 1'b0);
    mem_wr_i = 1'b1; mem_addr_i = 32'h200; mem_wr_data_i = 32'h11111111; mem_data_type_i = 2'd2;
    repeat (2) @(posedge clk_i);
    #1;
    check_eq("busy_before_abort", 128'(mem_busy_o), 128'(1));
    rsn_i = 1'b0; mem_wr_i = 1'b0;
    #1;
    check_eq("abort_ready", 128'(mem_ready_o), 128'(0));
    check_eq("abort_busy", 128'(mem_busy_o), 128'(0));
    @(posedge clk_i); #1;
    rsn_i = 1'b1;
    last_exp = '0; last_mask = '1;
    for (int i = 0; i < LAT + 2; i++) begin
      @(posedge clk_i); #1;
      check_eq("abort_no_ready", 128'(mem_ready_o), 128'(0));
    end
    do_req(1'b1, 1'b0, 32'h200, 32'h0, 2'd0, 1'b0);
    check_eq("abort_old", 128'(mem_data_o[31:0]), 128'(32'hCAFEF00D));

    // misaligned half and simultaneous read+write
    do_req(1'b0, 1'b1, 32'h300, 32'h00000000, 2'd2, 1'b0);
    do_req(1'b0, 1'b1, 32'h301, 32'h00005566, 2'd1, 1'b0);
    do_req(1'b1, 1'b0, 32'h300, 32'h0, 2'd0, 1'b0);
    check_eq("mis_b1", 128'(mem_data_o[15:8]), CHK ? 128'(8'h00) : 128'(8'h66));
    check_eq("mis_b2", 128'(mem_data_o[23:16]), CHK ? 128'(8'h00) : 128'(8'h55));
    do_req(1'b1, 1'b1, 32'h300, 32'h99999999, 2'd2, 1'b0);
    do_req(1'b1, 1'b0, 32'h300, 32'h0, 2'd0, 1'b0);
    check_eq("rdwr_dropped", 128'(mem_data_o[7:0]), 128'(8'h00));

    // randomized traffic
    for (int i = 0; i < 150; i++) begin
      logic [31:0] a;
      int unsigned p, r;
      r = $urandom_range(0, 3);
      case (r)
        0: a = 32'h400 + 32'($urandom_range(0, 63));
        1: a = 32'(MEM_BYTES) * 32'($urandom_range(1, 3)) + 32'h400 + 32'($urandom_range(0, 63));
        2: a = 32'(MEM_BYTES) - 32'($urandom_range(1, 4));
        default: a = {16'($urandom), 16'h0400} + 32'($urandom_range(0, 63));
      endcase
      p = $urandom_range(0, 9);
      do_req(p <= 3 || p == 9, p >= 4, a, $urandom, 2'($urandom_range(0, 2)), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
